serial_divider_32_bit: RTL
==========================

SERIAL_DIVIDER_32_BIT -- requirements
Module: serial_divider_32_bit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 signed_op  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start.
REQ-006 dividend  input  XLEN  numerator; sampled with start.
REQ-007 divisor  input  XLEN  denominator; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 quotient  output  XLEN  result quotient, held until the next done.
REQ-011 remainder  output  XLEN  result remainder, held until the next done.
REQ-012 div_by_zero  output  1  flags divisor==0 for the operation reported by done; held with the results.

Function
REQ-013 FSM states SHALL be IDLE, CALC, ADJ, DONE; busy=1 in CALC and ADJ only.
REQ-014 IDLE or DONE with start=1 -> CALC; latch operands; take magnitudes if signed_op; record result signs; clear the partial remainder; load the XLEN-cycle counter.
REQ-015 DONE with start=0 -> IDLE; IDLE with start=0 -> stays in IDLE.
REQ-016 CALC SHALL perform one radix-2 restoring step per cycle (shift, trial subtract of XLEN+1 bits, restore on borrow) for exactly XLEN cycles, then go to ADJ.
REQ-017 ADJ SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend is negative (signed only), register the results, then go to DONE.
REQ-018 done=1 only in DONE, giving latency XLEN+2 cycles from the start-sampling edge to the done cycle.
REQ-019 start while busy=1 SHALL be ignored, with no effect on state or operands.
REQ-020 Divide by zero SHALL give quotient=all ones, remainder=dividend, div_by_zero=1, for both signed and unsigned.
REQ-021 Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF) SHALL give quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-022 Remainder sign SHALL equal the dividend sign; the quotient SHALL truncate toward zero.
REQ-023 quotient, remainder, and div_by_zero SHALL change only on the edge that enters DONE.

Reset
REQ-024 rst=1 SHALL immediately force IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and counter=0.
REQ-025 rst during CALC or ADJ SHALL abort the operation with no done pulse; the next start after rst is released SHALL be processed normally.

Configuration
REQ-026 Macro DIV_EARLY_OUT_EN: when defined, divide-by-zero and signed overflow SHALL bypass CALC and ADJ and go from IDLE/DONE directly to DONE, giving 1-cycle latency with REQ-020/021 results.
REQ-027 Without DIV_EARLY_OUT_EN, every operation, including special cases, SHALL take exactly XLEN+2 cycles and produce REQ-020/021 results.

Verification
REQ-028 Unsigned 100 / 7 -> quotient=14, remainder=2, done exactly 34 cycles after start, busy high for 33 cycles.
REQ-029 Signed -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-030 5 / 0, signed and unsigned -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; done at 34 cycles, or at 1 cycle with DIV_EARLY_OUT_EN.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-032 rst pulsed 10 cycles into CALC -> busy=0 and outputs=0 immediately, no done pulse; a following 9 / 3 -> quotient=3, remainder=0.
REQ-033 start with 50 / 5 asserted mid-CALC of 100 / 7 -> ignored, results 14 and 2; start in the DONE cycle -> accepted back-to-back, next done 34 cycles later.

Source files
------------

// File: rtl/serial_divider_32_bit.sv
// Radix-2 restoring serial divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module serial_divider_32_bit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_q, r_rem, r_dvsr;
  logic            r_neg_q, r_neg_r, r_div0;
  logic [XLEN-1:0] r_quotient, r_remainder;
  logic            r_dbz;

  logic            w_accept, w_early, w_dvs_zero;
  logic            w_dvd_neg, w_dvs_neg;
  logic [XLEN-1:0] w_dvd_mag, w_dvs_mag;
  logic [XLEN:0]   w_shift, w_trial;
  logic            w_borrow;
  logic [XLEN-1:0] w_rem_step, w_q_fin, w_r_fin;

  assign w_accept   = start && (r_state == IDLE || r_state == DONE);
  assign w_dvs_zero = (divisor == '0);
  assign w_dvd_neg  = signed_op & dividend[XLEN-1];
  assign w_dvs_neg  = signed_op & divisor[XLEN-1];
  assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;

`ifdef DIV_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf   = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  assign w_early = w_accept && (w_dvs_zero || w_ovf);
`else
  assign w_early = 1'b0;
`endif

  // Trial subtract is XLEN+1 bits wide; its MSB is the borrow that restores.
  assign w_shift    = {r_rem, r_q[XLEN-1]};
  assign w_trial    = w_shift - {1'b0, r_dvsr};
  assign w_borrow   = w_trial[XLEN];
  assign w_rem_step = w_borrow ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];

  // Divide-by-zero yields |dividend| as remainder naturally; only the quotient needs forcing.
  assign w_q_fin = r_div0  ? '1 : (r_neg_q ? -r_q : r_q);
  assign w_r_fin = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_early ? DONE : CALC;
      CALC:    if (r_cnt == CW'(1)) w_next = ADJ;
      ADJ:     w_next = DONE;
      DONE:    w_next = start ? (w_early ? DONE : CALC) : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_dvsr      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_q     <= w_dvd_mag;
      r_rem   <= '0;
      r_dvsr  <= w_dvs_mag;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      r_div0  <= w_dvs_zero;
      r_cnt   <= CW'(XLEN);
      if (w_early) begin
        r_cnt       <= '0;
        r_quotient  <= w_dvs_zero ? '1 : dividend;
        r_remainder <= w_dvs_zero ? dividend : '0;
        r_dbz       <= w_dvs_zero;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_step;
      r_q   <= {r_q[XLEN-2:0], ~w_borrow};
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == ADJ) begin
      r_quotient  <= w_q_fin;
      r_remainder <= w_r_fin;
      r_dbz       <= r_div0;
    end
  end

  assign busy        = (r_state == CALC) || (r_state == ADJ);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
